// File: rtl/rsa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rsa_pkg                                                              |
// | ALU opcodes, sequencer state encoding and default operand width.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rsa_pkg;

  localparam int C_DW = 8;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_MOD = 2'b01;
  localparam logic [1:0] OP_GCD = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  // Every ALU step has an ISSUE (_I) state that strobes go and a WAIT (_W) state.
  typedef enum logic [4:0] {
    ST_IDLE      = 5'd0,
    ST_N_MUL_I   = 5'd1,
    ST_N_MUL_W   = 5'd2,
    ST_P_DEC_I   = 5'd3,
    ST_P_DEC_W   = 5'd4,
    ST_Q_DEC_I   = 5'd5,
    ST_Q_DEC_W   = 5'd6,
    ST_PHI_MUL_I = 5'd7,
    ST_PHI_MUL_W = 5'd8,
    ST_E_GCD_I   = 5'd9,
    ST_E_GCD_W   = 5'd10,
    ST_D_MUL_I   = 5'd11,
    ST_D_MUL_W   = 5'd12,
    ST_D_MOD_I   = 5'd13,
    ST_D_MOD_W   = 5'd14,
    ST_KEYOK     = 5'd15,
    ST_X_MUL_I   = 5'd16,
    ST_X_MUL_W   = 5'd17,
    ST_X_MOD_I   = 5'd18,
    ST_X_MOD_W   = 5'd19,
    ST_ERR       = 5'd20
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rsa_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rsa_sequencer_if                                                     |
// | Go/done handshake and operand bus between sequencer and shared ALU.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface rsa_sequencer_if #(
  parameter int DW = 8
) ();
  logic [1:0]      alu_op;
  logic [2*DW-1:0] alu_a;
  logic [DW-1:0]   alu_b;
  logic            alu_go;
  logic            alu_done;
  logic [2*DW-1:0] alu_res;

  modport master (
    output alu_op, alu_a, alu_b, alu_go,
    input  alu_done, alu_res
  );

  modport slave (
    input  alu_op, alu_a, alu_b, alu_go,
    output alu_done, alu_res
  );
endinterface
`default_nettype wire

// File: rtl/rsa_alu_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rsa_alu_port                                                         |
// | Issues one ALU op, holds its operands and watches for done/timeout.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rsa_alu_port
  import rsa_pkg::*;
#(
  parameter int DW      = C_DW,
  parameter int TIMEOUT = 255
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            i_issue,
  input  wire logic [1:0]      i_op,
  input  wire logic [2*DW-1:0] i_a,
  input  wire logic [DW-1:0]   i_b,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic [2*DW-1:0]      o_res,
  rsa_sequencer_if.master      alu
);

  localparam int c_CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic               r_wait;
  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_op;
  logic [2*DW-1:0]    r_a;
  logic [DW-1:0]      r_b;
  logic               w_expire;

  assign w_expire  = r_wait && !alu.alu_done && (r_cnt == c_CNT_W'(TIMEOUT));
  assign o_done    = r_wait && alu.alu_done;
  assign o_timeout = w_expire;
  assign o_res     = alu.alu_res;

  // Operands pass straight through on the issue cycle, then come from the hold registers.
  assign alu.alu_go = i_issue;
  assign alu.alu_op = i_issue ? i_op : r_op;
  assign alu.alu_a  = i_issue ? i_a  : r_a;
  assign alu.alu_b  = i_issue ? i_b  : r_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wait <= 1'b0;
      r_cnt  <= '0;
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else if (i_issue) begin
      r_wait <= 1'b1;
      r_cnt  <= '0;
      r_op   <= i_op;
      r_a    <= i_a;
      r_b    <= i_b;
    end else if (r_wait) begin
      if (alu.alu_done || w_expire) begin
        r_wait <= 1'b0;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rsa_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rsa_sequencer                                                        |
// | Key generation and modular-exponentiation control over a shared ALU. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rsa_sequencer
  import rsa_pkg::*;
#(
  parameter int DW      = C_DW,
  parameter int E_START = 2,
  parameter int TIMEOUT = 255
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          keygen,
  input  wire logic [3:0]    p,
  input  wire logic [3:0]    q,
  input  wire logic          crypt,
  input  wire logic          mode,
  input  wire logic [DW-1:0] msg,
  rsa_sequencer_if.master    alu,
  output logic               busy,
  output logic               key_valid,
  output logic [DW-1:0]      n_out,
  output logic [DW-1:0]      e_out,
  output logic [DW-1:0]      d_out,
  output logic [DW-1:0]      result,
  output logic               res_valid,
  output logic               err
);

  state_t          r_state, w_next;
  logic [3:0]      r_p, r_q;
  logic [DW-1:0]   r_n, r_pm1, r_qm1, r_phi, r_e, r_d;
  logic [DW-1:0]   r_acc, r_msg, r_cnt, r_result;
  logic [2*DW-1:0] r_t;
  logic            r_key_valid, r_res_valid;

  logic            w_issue, w_done, w_timeout;
  logic [1:0]      w_op;
  logic [2*DW-1:0] w_a, w_res;
  logic [DW-1:0]   w_b;
  logic            w_cmd_ready, w_kg, w_cr, w_msg_bad, w_res_one, w_e_ok, w_d_ok;

  assign w_cmd_ready = (r_state == ST_IDLE) || (r_state == ST_KEYOK) || (r_state == ST_ERR);
  assign w_kg        = keygen && w_cmd_ready;
  assign w_cr        = crypt && !keygen && (r_state == ST_KEYOK);
  assign w_msg_bad   = (msg >= r_n);
  assign w_res_one   = (w_res == (2*DW)'(1));
  assign w_e_ok      = (r_e < r_phi);
  assign w_d_ok      = (r_d < r_phi);

  rsa_alu_port #(
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) u_port (
    .clk       (clk),
    .reset     (reset),
    .i_issue   (w_issue),
    .i_op      (w_op),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_done    (w_done),
    .o_timeout (w_timeout),
    .o_res     (w_res),
    .alu       (alu)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_kg) begin
      w_next = ST_N_MUL_I;
    end else begin
      case (r_state)
        ST_KEYOK:     if (w_cr) w_next = w_msg_bad ? ST_ERR : ST_X_MUL_I;
        ST_N_MUL_I:   w_next = ST_N_MUL_W;
        ST_P_DEC_I:   w_next = ST_P_DEC_W;
        ST_Q_DEC_I:   w_next = ST_Q_DEC_W;
        ST_PHI_MUL_I: w_next = ST_PHI_MUL_W;
        ST_E_GCD_I:   w_next = w_e_ok ? ST_E_GCD_W : ST_ERR;
        ST_D_MUL_I:   w_next = w_d_ok ? ST_D_MUL_W : ST_ERR;
        ST_D_MOD_I:   w_next = ST_D_MOD_W;
        ST_X_MUL_I:   w_next = ST_X_MUL_W;
        ST_X_MOD_I:   w_next = ST_X_MOD_W;
        ST_N_MUL_W:   if (w_timeout) w_next = ST_ERR; else if (w_done) w_next = ST_P_DEC_I;
        ST_P_DEC_W:   if (w_timeout) w_next = ST_ERR; else if (w_done) w_next = ST_Q_DEC_I;
        ST_Q_DEC_W:   if (w_timeout) w_next = ST_ERR; else if (w_done) w_next = ST_PHI_MUL_I;
        ST_PHI_MUL_W: if (w_timeout) w_next = ST_ERR; else if (w_done) w_next = ST_E_GCD_I;
        ST_E_GCD_W:   if (w_timeout) w_next = ST_ERR;
                      else if (w_done) w_next = w_res_one ? ST_D_MUL_I : ST_E_GCD_I;
        ST_D_MUL_W:   if (w_timeout) w_next = ST_ERR; else if (w_done) w_next = ST_D_MOD_I;
        ST_D_MOD_W:   if (w_timeout) w_next = ST_ERR;
                      else if (w_done) w_next = w_res_one ? ST_KEYOK : ST_D_MUL_I;
        ST_X_MUL_W:   if (w_timeout) w_next = ST_ERR; else if (w_done) w_next = ST_X_MOD_I;
        ST_X_MOD_W:   if (w_timeout) w_next = ST_ERR;
                      else if (w_done) w_next = (r_cnt == DW'(1)) ? ST_KEYOK : ST_X_MUL_I;
        default:      w_next = r_state;
      endcase
    end
  end

  // Search bounds gate the strobe so a failed e/d bound issues no ALU op.
  always_comb begin
    w_issue = 1'b0;
    w_op    = OP_MUL;
    w_a     = '0;
    w_b     = '0;
    case (r_state)
      ST_N_MUL_I:   begin w_issue = 1'b1;   w_op = OP_MUL; w_a = (2*DW)'(r_p);   w_b = DW'(r_q); end
      ST_P_DEC_I:   begin w_issue = 1'b1;   w_op = OP_DEC; w_a = (2*DW)'(r_p);   end
      ST_Q_DEC_I:   begin w_issue = 1'b1;   w_op = OP_DEC; w_a = (2*DW)'(r_q);   end
      ST_PHI_MUL_I: begin w_issue = 1'b1;   w_op = OP_MUL; w_a = (2*DW)'(r_pm1); w_b = r_qm1; end
      ST_E_GCD_I:   begin w_issue = w_e_ok; w_op = OP_GCD; w_a = (2*DW)'(r_e);   w_b = r_phi; end
      ST_D_MUL_I:   begin w_issue = w_d_ok; w_op = OP_MUL; w_a = (2*DW)'(r_e);   w_b = r_d; end
      ST_D_MOD_I:   begin w_issue = 1'b1;   w_op = OP_MOD; w_a = r_t;            w_b = r_phi; end
      ST_X_MUL_I:   begin w_issue = 1'b1;   w_op = OP_MUL; w_a = (2*DW)'(r_acc); w_b = r_msg; end
      ST_X_MOD_I:   begin w_issue = 1'b1;   w_op = OP_MOD; w_a = r_t;            w_b = r_n; end
      default:      ;
    endcase
    busy = !w_cmd_ready;
    err  = (r_state == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_p         <= '0;
      r_q         <= '0;
      r_n         <= '0;
      r_pm1       <= '0;
      r_qm1       <= '0;
      r_phi       <= '0;
      r_e         <= '0;
      r_d         <= '0;
      r_t         <= '0;
      r_acc       <= '0;
      r_msg       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_key_valid <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (w_kg) begin
        r_p         <= p;
        r_q         <= q;
        r_key_valid <= 1'b0;
      end else if (w_cr) begin
        r_msg <= msg;
        r_cnt <= mode ? r_d : r_e;
        r_acc <= DW'(1);
        if (w_msg_bad) r_key_valid <= 1'b0;
      end else if (w_done) begin
        case (r_state)
          ST_N_MUL_W:   r_n   <= w_res[DW-1:0];
          ST_P_DEC_W:   r_pm1 <= w_res[DW-1:0];
          ST_Q_DEC_W:   r_qm1 <= w_res[DW-1:0];
          ST_PHI_MUL_W: begin
            r_phi <= w_res[DW-1:0];
            r_e   <= DW'(E_START);
          end
          ST_E_GCD_W: begin
            if (w_res_one) r_d <= DW'(1);
            else           r_e <= r_e + DW'(1);
          end
          ST_D_MUL_W, ST_X_MUL_W: r_t <= w_res;
          ST_D_MOD_W: begin
            if (w_res_one) r_key_valid <= 1'b1;
            else           r_d <= r_d + DW'(1);
          end
          ST_X_MOD_W: begin
            r_acc <= w_res[DW-1:0];
            r_cnt <= r_cnt - DW'(1);
            if (r_cnt == DW'(1)) begin
              r_result    <= w_res[DW-1:0];
              r_res_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign key_valid = r_key_valid;
  assign n_out     = r_n;
  assign e_out     = r_e;
  assign d_out     = r_d;
  assign result    = r_result;
  assign res_valid = r_res_valid;

endmodule
`default_nettype wire
